capture_mem: RTL

CAPTURE_MEM -- requirements
Module: capture_mem

---
 rtl/capture_mem_pkg.sv | 6 +
 rtl/capture_mem_ram.sv | 20 ++
 rtl/capture_mem.sv | 133 +++++++++++++
 3 files changed

// File: rtl/capture_mem_pkg.sv
// capture_mem_pkg: shared state encoding and default geometry for capture_mem
package capture_mem_pkg;
  localparam int DEF_AW = 10;
  localparam int DEF_MDW = 32;
  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;
endpackage

// File: rtl/capture_mem_ram.sv
// capture_mem_ram: simple dual-port RAM, one write port, one registered read port
module capture_mem_ram #(
  parameter int W = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  // storage is never cleared; read data appears one cycle after re
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/capture_mem.sv
// capture_mem: circular capture buffer read back newest-first; CAPTURE_MEM_PARITY_EN adds per-word even parity
module capture_mem
  import capture_mem_pkg::*;
#(
  parameter int MDW = DEF_MDW,
  parameter int AW = DEF_AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm,
  input  logic [MDW-1:0] mwr_tdata,
  input  logic           mwr_tvalid,
  input  logic           mwr_tlast,
  output logic [MDW-1:0] mrd_tdata,
  output logic           mrd_tvalid,
  input  logic           mrd_tready,
  output logic           mrd_tlast,
  output logic [AW:0]    stored_count,
  output logic           capture_done,
`ifdef CAPTURE_MEM_PARITY_EN
  output logic           parity_err,
`endif
  output logic           overflow
);
`ifdef CAPTURE_MEM_PARITY_EN
  localparam int RW = MDW + 1;
`else
  localparam int RW = MDW;
`endif
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  state_t state, state_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] rd_left, cnt_nx;
  logic [RW-1:0] wdata, rdata, out_word, sk_word;
  logic out_valid, out_last, sk_valid, sk_last, rv, rv_last;
  logic wr_acc, pop, issue;
  logic [1:0] occ;
`ifdef CAPTURE_MEM_PARITY_EN
  assign wdata = {^mwr_tdata, mwr_tdata};
`else
  assign wdata = mwr_tdata;
`endif
  assign mrd_tdata = out_word[MDW-1:0];
  assign mrd_tvalid = out_valid;
  assign mrd_tlast = out_last;
  // write acceptance, read issue credit (output + skid slots) and next state
  always_comb begin
    wr_acc = state == CAPTURE && mwr_tvalid && !arm;
    pop = out_valid && mrd_tready;
    cnt_nx = (stored_count == FULL) ? FULL : stored_count + 1'b1;
    occ = {1'b0, out_valid} + {1'b0, sk_valid} + {1'b0, rv};
    issue = state == READOUT && rd_left != '0 && !arm && (occ - {1'b0, pop}) < 2'd2;
    state_nx = arm ? CAPTURE
             : (wr_acc && mwr_tlast) ? READOUT
             : (state == READOUT && pop && out_last) ? IDLE : state;
  end
  capture_mem_ram #(.W(RW), .AW(AW)) u_ram (
    .clk(clk), .we(wr_acc), .waddr(wr_ptr), .wdata(wdata),
    .re(issue), .raddr(rd_ptr), .rdata(rdata)
  );
  // pointers, counters, sticky flags and the output/skid readout pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_left <= '0;
      stored_count <= '0;
      capture_done <= 1'b0;
      overflow <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_word <= '0;
      sk_valid <= 1'b0;
      rv <= 1'b0;
`ifdef CAPTURE_MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (arm) begin
        wr_ptr <= '0;
        rd_left <= '0;
        stored_count <= '0;
        capture_done <= 1'b0;
        overflow <= 1'b0;
        out_valid <= 1'b0;
        sk_valid <= 1'b0;
        rv <= 1'b0;
`ifdef CAPTURE_MEM_PARITY_EN
        parity_err <= 1'b0;
`endif
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + 1'b1;
          stored_count <= cnt_nx;
          overflow <= overflow | (stored_count == FULL);
          if (mwr_tlast) begin
            capture_done <= 1'b1;
            rd_ptr <= wr_ptr;
            rd_left <= cnt_nx;
          end
        end
        rv <= issue;
        rv_last <= issue && rd_left == {{AW{1'b0}}, 1'b1};
        if (issue) begin
          rd_ptr <= rd_ptr - 1'b1;
          rd_left <= rd_left - 1'b1;
        end
        if (!out_valid || pop) begin
          out_valid <= sk_valid | rv;
          if (sk_valid) begin
            out_word <= sk_word;
            out_last <= sk_last;
            sk_valid <= rv;
            sk_word <= rdata;
            sk_last <= rv_last;
          end else if (rv) begin
            out_word <= rdata;
            out_last <= rv_last;
          end
        end else if (rv) begin
          sk_valid <= 1'b1;
          sk_word <= rdata;
          sk_last <= rv_last;
        end
`ifdef CAPTURE_MEM_PARITY_EN
        if (pop) parity_err <= parity_err | (^out_word);
`endif
      end
    end
  end
endmodule
